// File: rtl/hamming_pkg.sv
// rtl/hamming_pkg.sv - Hamming helper functions, bit mapping and scrub FSM states
// Defining HAMMING_SECDED_EN adds an overall even-parity bit above the Hamming word.
package hamming_pkg;

   localparam int MAX_DW = 32;
   localparam int MAX_CW = 64;

`ifdef HAMMING_SECDED_EN
   localparam bit SECDED = 1'b1;
`else
   localparam bit SECDED = 1'b0;
`endif

   typedef enum logic [2:0] {ST_IDLE, ST_READ, ST_CHECK, ST_FIX, ST_DONE} scrub_state_e;

   // Smallest p with 2^p >= dw+p+1; scanning downwards leaves the minimum in p.
   function automatic int par_w(input int dw);
      int p;
      p = 0;
      for (int k = 7; k >= 1; k--)
         if ((1 << k) >= dw + k + 1) p = k;
      return p;
   endfunction

   function automatic bit is_pow2(input int x);
      return (x > 0) && ((x & (x - 1)) == 0);
   endfunction

   function automatic logic [MAX_CW-1:0] encode(input logic [MAX_DW-1:0] d, input int dw);
      logic [MAX_CW-1:0] cw;
      logic              par;
      int                n, pw, j;
      cw = '0;
      pw = par_w(dw);
      n  = dw + pw;
      j  = 0;
      for (int pos = 1; pos <= MAX_CW; pos++)
         if (pos <= n && !is_pow2(pos)) begin
            cw[pos-1] = d[j];
            j++;
         end
      for (int k = 0; k < 8; k++)
         if (k < pw) begin
            par = 1'b0;
            for (int pos = 1; pos <= MAX_CW; pos++)
               if (pos <= n && ((pos >> k) & 1) == 1) par = par ^ cw[pos-1];
            cw[(1 << k) - 1] = par;
         end
      if (SECDED) cw[n] = ^cw;
      return cw;
   endfunction

   function automatic logic [MAX_DW-1:0] extract(input logic [MAX_CW-1:0] cw, input int dw);
      logic [MAX_DW-1:0] d;
      int                n, j;
      d = '0;
      n = dw + par_w(dw);
      j = 0;
      for (int pos = 1; pos <= MAX_CW; pos++)
         if (pos <= n && !is_pow2(pos)) begin
            d[j] = cw[pos-1];
            j++;
         end
      return d;
   endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// rtl/hamming_syndrome.sv - combinational syndrome and overall-parity check of one codeword
// Overall parity is only meaningful when HAMMING_SECDED_EN is defined; otherwise it reads 0.
module hamming_syndrome
   import hamming_pkg::*;
#(
   parameter  int DATA_W = 4,
   localparam int PAR_W  = par_w(DATA_W),
   localparam int CW     = DATA_W + PAR_W,
   localparam int CW_T   = CW + int'(SECDED)
) (
   input  logic [CW_T-1:0]  cw_i,
   output logic [PAR_W-1:0] syn_o,
   output logic             par_fail_o
);

   // Syndrome is the XOR of the positions of all set bits.
   always_comb begin
      syn_o = '0;
      for (int pos = 1; pos <= CW; pos++)
         if (cw_i[pos-1]) syn_o = syn_o ^ PAR_W'(pos);
      par_fail_o = SECDED ? ^cw_i : 1'b0;
   end

endmodule

// File: rtl/hamming_scrub_bank.sv
// rtl/hamming_scrub_bank.sv - multi-channel Hamming codeword store with load, fault injection and scrubbing
// HAMMING_SECDED_EN selects SECDED decoding; default is plain SEC.
module hamming_scrub_bank
   import hamming_pkg::*;
#(
   parameter  int DATA_W = 4,
   parameter  int N_CH   = 2,
   parameter  int CNT_W  = 8,
   localparam int PAR_W  = par_w(DATA_W),
   localparam int CW     = DATA_W + PAR_W,
   localparam int CW_T   = CW + int'(SECDED),
   localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load_valid,
   output logic                 load_ready,
   input  logic [CH_W-1:0]      load_ch,
   input  logic [DATA_W-1:0]    load_data,
   input  logic                 inj_valid,
   input  logic [CH_W-1:0]      inj_ch,
   input  logic [CW_T-1:0]      inj_mask,
   input  logic                 scrub_start,
   output logic                 scrub_busy,
   output logic                 scrub_done,
   input  logic                 err_clr,
   output logic [N_CH-1:0]      err_flag,
   output logic [CNT_W-1:0]     corr_cnt,
   output logic [CNT_W-1:0]     uncorr_cnt,
   input  logic [CH_W-1:0]      rd_ch,
   output logic [DATA_W-1:0]    rd_data,
   output logic [N_CH*CW_T-1:0] cw_out
);

   logic [CW_T-1:0]  cw_q [N_CH];
   scrub_state_e     state_q;
   logic [CH_W-1:0]  ch_q;
   logic [CW_T-1:0]  lat_q;
   logic [PAR_W-1:0] syn_q;
   logic             pf_q;
   logic             ready_q, busy_q, done_q;
   logic [N_CH-1:0]  flag_q;
   logic [CNT_W-1:0] corr_q, uncorr_q;

   logic [CW_T-1:0]  enc_d, fix_cw_d;
   logic [PAR_W-1:0] syn_d;
   logic             pf_d, corr_d, uncorr_d;
   logic             load_fire, inj_fire;

   hamming_syndrome #(.DATA_W(DATA_W)) u_syn (
      .cw_i       (lat_q),
      .syn_o      (syn_d),
      .par_fail_o (pf_d)
   );

   assign load_fire = load_valid & ready_q;
   assign inj_fire  = inj_valid & ~busy_q;
   assign enc_d     = CW_T'(encode(MAX_DW'(load_data), DATA_W));

   // In SEC mode pf_q is constant 0, which collapses this to the plain SEC decision.
   always_comb begin
      fix_cw_d = lat_q;
      corr_d   = 1'b0;
      uncorr_d = 1'b0;
      if (syn_q != '0 || pf_q) begin
         if (SECDED && !pf_q) begin
            uncorr_d = 1'b1;
         end else if (syn_q == '0) begin
            fix_cw_d = lat_q ^ (CW_T'(1) << CW);
            corr_d   = 1'b1;
         end else if (32'(syn_q) <= 32'(CW)) begin
            fix_cw_d = lat_q ^ (CW_T'(1) << (syn_q - 1'b1));
            corr_d   = 1'b1;
         end else begin
            uncorr_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int c = 0; c < N_CH; c++) cw_q[c] <= '0;
         state_q  <= ST_IDLE;
         ch_q     <= '0;
         lat_q    <= '0;
         syn_q    <= '0;
         pf_q     <= 1'b0;
         ready_q  <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         flag_q   <= '0;
         corr_q   <= '0;
         uncorr_q <= '0;
      end else begin
         for (int c = 0; c < N_CH; c++) begin
            if (load_fire && 32'(load_ch) == 32'(c))
               cw_q[c] <= enc_d;
            else if (inj_fire && 32'(inj_ch) == 32'(c))
               cw_q[c] <= cw_q[c] ^ inj_mask;
            else if (state_q == ST_FIX && corr_d && 32'(ch_q) == 32'(c))
               cw_q[c] <= fix_cw_d;
         end

         if (err_clr) begin
            corr_q   <= '0;
            uncorr_q <= '0;
            flag_q   <= '0;
         end else if (state_q == ST_FIX && (corr_d || uncorr_d)) begin
            for (int c = 0; c < N_CH; c++)
               if (32'(ch_q) == 32'(c)) flag_q[c] <= 1'b1;
            if (corr_d && corr_q != '1) corr_q <= corr_q + 1'b1;
            if (uncorr_d && uncorr_q != '1) uncorr_q <= uncorr_q + 1'b1;
         end

         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: if (scrub_start) begin
               state_q <= ST_READ;
               ch_q    <= '0;
               busy_q  <= 1'b1;
               ready_q <= 1'b0;
            end
            ST_READ: begin
               for (int c = 0; c < N_CH; c++)
                  if (32'(ch_q) == 32'(c)) lat_q <= cw_q[c];
               state_q <= ST_CHECK;
            end
            ST_CHECK: begin
               syn_q   <= syn_d;
               pf_q    <= pf_d;
               state_q <= ST_FIX;
            end
            ST_FIX: if (32'(ch_q) == 32'(N_CH - 1)) begin
               state_q <= ST_DONE;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
            end else begin
               ch_q    <= ch_q + 1'b1;
               state_q <= ST_READ;
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
               ready_q <= 1'b1;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      rd_data = '0;
      cw_out  = '0;
      for (int c = 0; c < N_CH; c++) begin
         cw_out[c*CW_T +: CW_T] = cw_q[c];
         if (32'(rd_ch) == 32'(c)) rd_data = DATA_W'(extract(MAX_CW'(cw_q[c]), DATA_W));
      end
   end

   assign load_ready = ready_q;
   assign scrub_busy = busy_q;
   assign scrub_done = done_q;
   assign err_flag   = flag_q;
   assign corr_cnt   = corr_q;
   assign uncorr_cnt = uncorr_q;

endmodule

// File: tb/tb_hamming_scrub_bank.sv
// tb/tb_hamming_scrub_bank.sv - scoreboard bench for hamming_scrub_bank (4/2/8 and 11/4/3 instances)
// Expectations follow HAMMING_SECDED_EN when it is defined for the build.
module tb_hamming_scrub_bank;

`ifdef HAMMING_SECDED_EN
   localparam bit SD = 1'b1;
`else
   localparam bit SD = 1'b0;
`endif
   localparam int ACW = 7 + int'(SD);
   localparam int BCW = 15 + int'(SD);

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic             a_load_valid, a_load_ready, a_load_ch, a_inj_valid, a_inj_ch;
   logic [3:0]       a_load_data, a_rd_data;
   logic [ACW-1:0]   a_inj_mask;
   logic             a_scrub_start, a_scrub_busy, a_scrub_done, a_err_clr, a_rd_ch;
   logic [1:0]       a_err_flag;
   logic [7:0]       a_corr, a_uncorr;
   logic [2*ACW-1:0] a_cw_out;

   logic             b_load_valid, b_load_ready, b_inj_valid;
   logic [1:0]       b_load_ch, b_inj_ch, b_rd_ch;
   logic [10:0]      b_load_data, b_rd_data;
   logic [BCW-1:0]   b_inj_mask;
   logic             b_scrub_start, b_scrub_busy, b_scrub_done, b_err_clr;
   logic [3:0]       b_err_flag;
   logic [2:0]       b_corr, b_uncorr;
   logic [4*BCW-1:0] b_cw_out;

   hamming_scrub_bank u_dut_a (
      .clk(clk), .rst(rst),
      .load_valid(a_load_valid), .load_ready(a_load_ready), .load_ch(a_load_ch), .load_data(a_load_data),
      .inj_valid(a_inj_valid), .inj_ch(a_inj_ch), .inj_mask(a_inj_mask),
      .scrub_start(a_scrub_start), .scrub_busy(a_scrub_busy), .scrub_done(a_scrub_done),
      .err_clr(a_err_clr), .err_flag(a_err_flag), .corr_cnt(a_corr), .uncorr_cnt(a_uncorr),
      .rd_ch(a_rd_ch), .rd_data(a_rd_data), .cw_out(a_cw_out)
   );

   hamming_scrub_bank #(.DATA_W(11), .N_CH(4), .CNT_W(3)) u_dut_b (
      .clk(clk), .rst(rst),
      .load_valid(b_load_valid), .load_ready(b_load_ready), .load_ch(b_load_ch), .load_data(b_load_data),
      .inj_valid(b_inj_valid), .inj_ch(b_inj_ch), .inj_mask(b_inj_mask),
      .scrub_start(b_scrub_start), .scrub_busy(b_scrub_busy), .scrub_done(b_scrub_done),
      .err_clr(b_err_clr), .err_flag(b_err_flag), .corr_cnt(b_corr), .uncorr_cnt(b_uncorr),
      .rd_ch(b_rd_ch), .rd_data(b_rd_data), .cw_out(b_cw_out)
   );

   int          n_run  = 0;
   int          n_fail = 0;
   logic [63:0] sb_q[$];
   string       sb_tag[$];
   logic [63:0] a_exp [2];
   logic [63:0] b_exp [4];
   logic [10:0] b_dat [4];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic sb_push(input string tag, input logic [63:0] exp);
      sb_tag.push_back(tag);
      sb_q.push_back(exp);
   endtask

   task automatic sb_pop_chk(input logic [63:0] got);
      if (sb_q.size() == 0) begin
         chk("sb_empty", 64'(sb_q.size()), 64'd1);
      end else begin
         chk(sb_tag.pop_front(), got, sb_q.pop_front());
      end
   endtask

   // Independent encoder: check bits equal the XOR of the indices of set data positions.
   function automatic logic [63:0] m_enc(input logic [31:0] d, input int dw);
      logic [63:0] w;
      int          pw, n, j, s;
      pw = 1;
      while ((1 << pw) < dw + pw + 1) pw++;
      n = dw + pw;
      j = 0;
      s = 0;
      w = '0;
      for (int pos = 1; pos <= n; pos++)
         if ((pos & (pos - 1)) != 0) begin
            w[pos-1] = d[j];
            if (d[j]) s = s ^ pos;
            j++;
         end
      for (int k = 0; k < pw; k++) w[(1 << k) - 1] = s[k];
      if (SD) w[n] = ^w;
      return w;
   endfunction

   function automatic logic [63:0] a_cw(input int ch);
      return 64'(a_cw_out[ch*ACW +: ACW]);
   endfunction

   function automatic logic [63:0] b_cw(input int ch);
      return 64'(b_cw_out[ch*BCW +: BCW]);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic a_push_all(input logic [63:0] c, input logic [63:0] u, input logic [63:0] f);
      sb_push("a_cw0", a_exp[0]);
      sb_push("a_cw1", a_exp[1]);
      sb_push("a_corr", c);
      sb_push("a_uncorr", u);
      sb_push("a_flag", f);
   endtask

   task automatic b_push_all(input logic [63:0] c, input logic [63:0] u, input logic [63:0] f);
      for (int i = 0; i < 4; i++) sb_push($sformatf("b_cw%0d", i), b_exp[i]);
      sb_push("b_corr", c);
      sb_push("b_uncorr", u);
      sb_push("b_flag", f);
   endtask

   task automatic a_load(input logic ch, input logic [3:0] d);
      a_load_valid = 1'b1;
      a_load_ch    = ch;
      a_load_data  = d;
      a_exp[ch]    = m_enc(32'(d), 4);
      sb_push("a_load", a_exp[ch]);
      tick();
      a_load_valid = 1'b0;
      sb_pop_chk(a_cw(int'(ch)));
   endtask

   // poke: during the pass try a load, an inject and a second start, all of which must be ignored
   task automatic a_scrub(input bit poke);
      int lat;
      a_scrub_start = 1'b1;
      tick();
      a_scrub_start = 1'b0;
      chk("a_busy_rise", 64'(a_scrub_busy), 64'd1);
      lat = 0;
      while (!a_scrub_done && lat < 40) begin
         a_load_valid  = poke && lat == 1;
         a_inj_valid   = poke && lat == 1;
         a_scrub_start = poke && lat == 1;
         a_load_ch     = 1'b0;
         a_load_data   = 4'h2;
         a_inj_ch      = 1'b1;
         a_inj_mask    = '1;
         if (poke && lat == 1) chk("a_ready_busy", 64'(a_load_ready), 64'd0);
         tick();
         lat++;
      end
      a_load_valid  = 1'b0;
      a_inj_valid   = 1'b0;
      a_scrub_start = 1'b0;
      chk("a_done_lat", 64'(lat), 64'd6);
      for (int i = 0; i < 5; i++)
         case (i)
            0: sb_pop_chk(a_cw(0));
            1: sb_pop_chk(a_cw(1));
            2: sb_pop_chk(64'(a_corr));
            3: sb_pop_chk(64'(a_uncorr));
            default: sb_pop_chk(64'(a_err_flag));
         endcase
      tick();
      chk("a_done_pulse", 64'(a_scrub_done), 64'd0);
      chk("a_busy_end", 64'(a_scrub_busy), 64'd0);
      chk("a_ready_end", 64'(a_load_ready), 64'd1);
   endtask

   // clr_fix: assert err_clr in the FIX cycle of channel 0
   task automatic b_scrub(input bit clr_fix);
      int lat;
      b_scrub_start = 1'b1;
      tick();
      b_scrub_start = 1'b0;
      chk("b_busy_rise", 64'(b_scrub_busy), 64'd1);
      lat = 0;
      while (!b_scrub_done && lat < 60) begin
         b_err_clr = clr_fix && lat == 2;
         tick();
         lat++;
      end
      b_err_clr = 1'b0;
      chk("b_done_lat", 64'(lat), 64'd12);
      for (int i = 0; i < 4; i++) sb_pop_chk(b_cw(i));
      sb_pop_chk(64'(b_corr));
      sb_pop_chk(64'(b_uncorr));
      sb_pop_chk(64'(b_err_flag));
      tick();
   endtask

   task automatic b_inject_single(input int ch);
      b_inj_valid = 1'b1;
      b_inj_ch    = 2'(ch);
      b_inj_mask  = BCW'(1) << $urandom_range(0, 14);
      tick();
      b_inj_valid = 1'b0;
   endtask

   initial begin
      int seen;
      a_load_valid = 0; a_load_ch = 0; a_load_data = 0; a_inj_valid = 0; a_inj_ch = 0; a_inj_mask = 0;
      a_scrub_start = 0; a_err_clr = 0; a_rd_ch = 0;
      b_load_valid = 0; b_load_ch = 0; b_load_data = 0; b_inj_valid = 0; b_inj_ch = 0; b_inj_mask = 0;
      b_scrub_start = 0; b_err_clr = 0; b_rd_ch = 0;
      tick();
      tick();
      chk("rst_a_cw", 64'(a_cw_out), 64'd0);
      chk("rst_a_ready", 64'(a_load_ready), 64'd1);
      chk("rst_a_busy", 64'(a_scrub_busy), 64'd0);
      chk("rst_a_done", 64'(a_scrub_done), 64'd0);
      chk("rst_a_flag", 64'(a_err_flag), 64'd0);
      chk("rst_a_corr", 64'(a_corr), 64'd0);
      chk("rst_a_uncorr", 64'(a_uncorr), 64'd0);
      chk("rst_b_cw", 64'(b_cw_out), 64'd0);
      chk("rst_b_ready", 64'(b_load_ready), 64'd1);
      rst = 1'b0;
      tick();

      a_load(1'b0, 4'hB);
      chk("t1_cw55", a_cw(0), 64'h55);
      a_load(1'b1, 4'h7);
      a_load(1'b1, 4'h0);
      chk("t1_cw00", a_cw(1), 64'h00);
      a_rd_ch = 1'b0;
      #1;
      chk("t1_rd0", 64'(a_rd_data), 64'hB);

      // Same channel: load wins over inject.
      a_load_valid = 1'b1; a_load_ch = 1'b1; a_load_data = 4'h3;
      a_inj_valid = 1'b1; a_inj_ch = 1'b1; a_inj_mask = ACW'(1);
      a_exp[1] = m_enc(32'h3, 4);
      sb_push("a_ld_inj_same", a_exp[1]);
      tick();
      sb_pop_chk(a_cw(1));

      // Different channels: both apply.
      a_load_data = 4'h5; a_inj_ch = 1'b0; a_inj_mask = ACW'(4);
      a_exp[1] = m_enc(32'h5, 4);
      sb_push("a_inj_diff", a_exp[0] ^ 64'h4);
      sb_push("a_ld_diff", a_exp[1]);
      tick();
      a_load_valid = 1'b0; a_inj_valid = 1'b0;
      sb_pop_chk(a_cw(0));
      sb_pop_chk(a_cw(1));
      chk("t2_cw51", a_cw(0), 64'h51);

      a_push_all(64'd1, 64'd0, 64'b01);
      a_scrub(1'b1);

      a_err_clr = 1'b1;
      tick();
      a_err_clr = 1'b0;
      chk("clr_corr", 64'(a_corr), 64'd0);
      chk("clr_flag", 64'(a_err_flag), 64'd0);

      // Double error at positions 1 and 5.
      a_inj_valid = 1'b1; a_inj_ch = 1'b0; a_inj_mask = ACW'(8'h11);
      tick();
      a_inj_valid = 1'b0;
      if (SD) begin
         a_exp[0] = a_exp[0] ^ 64'h11;
         a_push_all(64'd0, 64'd1, 64'b01);
      end else begin
         a_exp[0] = a_exp[0] ^ 64'h11 ^ 64'h08;
         a_push_all(64'd1, 64'd0, 64'b01);
      end
      a_scrub(1'b0);
      chk("t3_cw", a_cw(0), SD ? 64'h44 : 64'h4C);

      // Wide instance: random data, one single-bit error per channel, one pass.
      for (int c = 0; c < 4; c++) begin
         b_dat[c]     = 11'($urandom_range(0, 2047));
         b_load_valid = 1'b1;
         b_load_ch    = 2'(c);
         b_load_data  = b_dat[c];
         b_exp[c]     = m_enc(32'(b_dat[c]), 11);
         sb_push("b_load", b_exp[c]);
         tick();
         b_load_valid = 1'b0;
         sb_pop_chk(b_cw(c));
      end
      for (int c = 0; c < 4; c++) b_inject_single(c);
      b_push_all(64'd4, 64'd0, 64'hF);
      b_scrub(1'b0);
      for (int c = 0; c < 4; c++) begin
         b_rd_ch = 2'(c);
         #1;
         chk($sformatf("b_rd%0d", c), 64'(b_rd_data), 64'(b_dat[c]));
      end

      // Counter saturates at 3'b111.
      for (int k = 0; k < 4; k++) begin
         b_inject_single(k);
         b_push_all((5 + k > 7) ? 64'd7 : 64'(5 + k), 64'd0, 64'hF);
         b_scrub(1'b0);
      end

      // Clear in the same cycle as a FIX increment.
      b_inject_single(0);
      b_push_all(64'd0, 64'd0, 64'h0);
      b_scrub(1'b1);

      // Reset in the middle of a pass.
      a_scrub_start = 1'b1;
      tick();
      a_scrub_start = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      #1;
      chk("rst_mid_cw", 64'(a_cw_out), 64'd0);
      chk("rst_mid_busy", 64'(a_scrub_busy), 64'd0);
      chk("rst_mid_done", 64'(a_scrub_done), 64'd0);
      tick();
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (a_scrub_done) seen++;
      end
      chk("rst_mid_nodone", 64'(seen), 64'd0);
      chk("rst_mid_ready", 64'(a_load_ready), 64'd1);
      chk("sb_drained", 64'(sb_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

endmodule
